bdos_console: RTL and testbench
===============================

# bdos_console

Hardware responder for CP/M BDOS console-output calls made by the i8080 core. It watches opcode fetches, and on a fetch from the BDOS entry address it stalls the CPU. It then performs function 2 (print character in E) or function 9 (print `$`-terminated string at DE) by reading system RAM and streaming bytes out on a valid/ready console port. It sits between the i8080 core, the RAM read port and the console UART/transmit path, replacing the simulation-only BDOS trap.

## Interface

Parameters:
- `BDOS_ADDR`, 16'h0005, fetch address that triggers a call.
- `TERM`, 8'h24 (`$`), function-9 string terminator.
- `MAX_LEN`, 256, maximum characters emitted per function-9 call (1..65535).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `m1` in 1: one-cycle strobe, first cycle of an opcode fetch.
- `pc` in 16: fetch address, valid while `m1`=1.
- `c_reg` in 8: CPU register C, valid while `m1`=1.
- `de` in 16: CPU register pair {D,E}, valid while `m1`=1.
- `hold` out 1: stall request to the CPU control unit.
- `mem_rd` out 1: RAM read request.
- `mem_addr` out 16: RAM read address.
- `mem_data` in 8: RAM read data, valid exactly one cycle after `mem_rd`.
- `tx_data` out 8: console byte.
- `tx_valid` out 1: console byte valid.
- `tx_ready` in 1: console sink ready.
- `err_valid` out 1: one-cycle pulse on an unsupported call or a length overrun.
- `err_code` out 8: offending C value, or 8'hFF on overrun.

## Operation

- States: IDLE, FETCH, CHECK, SEND.
- Trigger: `m1`=1, `pc`==`BDOS_ADDR` and state IDLE.
  - `c_reg`==2: latch `de[7:0]` into `tx_data`, go to SEND.
  - `c_reg`==9: latch `ptr`<=`de`, `count`<=0, go to FETCH.
  - Any other `c_reg`: `err_valid`=1 next cycle, `err_code`=`c_reg`, stay IDLE, no `hold`.
- FETCH: `mem_rd`=1, `mem_addr`=`ptr`, go to CHECK.
- CHECK:
  - `mem_data`==`TERM`: go to IDLE.
  - Else if `count`==`MAX_LEN`: pulse `err_valid` with `err_code`=8'hFF, go to IDLE.
  - Else: `tx_data`<=`mem_data`, go to SEND.
- SEND: `tx_valid`=1. On `tx_valid&&tx_ready`:
  - Function 2: go to IDLE.
  - Function 9: `ptr`<=`ptr`+1, `count`<=`count`+1, go to FETCH.
- `ptr` is 16-bit and wraps from 16'hFFFF to 16'h0000 with no error. `count` is 16-bit and saturates in practice at `MAX_LEN`.
- `hold` = (state != IDLE), registered.
- `tx_data` is stable for the whole time `tx_valid`=1. `tx_valid` never drops without a handshake.
- `m1` pulses while not IDLE are ignored, since the CPU is stalled.
- Reset values: state IDLE; `hold`, `mem_rd`, `tx_valid`, `err_valid` = 0; `tx_data`, `err_code`, `mem_addr`, `ptr`, `count` = 0.
- Reset asserted mid-call aborts immediately. The in-flight byte is dropped and `hold` drops asynchronously.

## Timing

- Trigger seen at the rising edge of cycle T. `hold`=1 from T+1. The CPU samples `hold` no earlier than T+1.
- Function 2 with `tx_ready`=1: `tx_valid` high in T+1, handshake in T+1, `hold`=0 from T+2.
- Function 9: FETCH at T+1, CHECK at T+2, first SEND at T+3.
  - Each character costs 3 cycles when `tx_ready`=1, plus one cycle per cycle of backpressure.
  - Terminator detected in CHECK: `hold`=0 the following cycle.
  - Empty string (`$` at DE): `hold` high for exactly T+1..T+2.
- `err_valid` is a single-cycle pulse; the unsupported-call error appears at T+1.
- `mem_rd` is high only in FETCH, one cycle per character.

## Test plan

- C=2, E=8'h41, `tx_ready`=1 -> one byte 8'h41 at T+1, `hold` high for 1 cycle only, no `mem_rd`.
- C=9, DE=16'h0200, RAM "HI$", `tx_ready`=1 -> bytes 8'h48, 8'h49 at T+3 and T+6; `mem_rd` addresses 0200, 0201, 0202; `hold`=0 at T+10.
- Same string with `tx_ready` low for 4 cycles on 'H' -> `tx_data`=8'h48 held stable throughout; total `hold` high time increases by exactly 4 cycles.
- C=9, DE=16'hFFFF, RAM[FFFF]='A', RAM[0000]='$' -> emits 8'h41; second read at 16'h0000; completes with no error.
- C=8'h0B -> `err_valid` pulse at T+1 with `err_code`=8'h0B; `hold` stays 0. Separately, C=9 with `MAX_LEN`=4 and no terminator -> 4 bytes emitted, then `err_code`=8'hFF and `hold` released.
- Assert `rst` low during SEND of the second character of a string -> `hold`, `tx_valid` and `mem_rd` go 0 immediately. After release, a new C=2 call works normally.

Source files
------------

// File: rtl/bdos_console.sv
// CP/M BDOS console-output responder: traps fetches from the BDOS entry point and
// services function 2 (print E) and function 9 (print '$'-terminated string at DE).
module bdos_console #(
    parameter logic [15:0] BDOS_ADDR = 16'h0005,
    parameter logic [7:0]  TERM      = 8'h24,
    parameter int          MAX_LEN   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m1,
    input  logic [15:0] pc,
    input  logic [7:0]  c_reg,
    input  logic [15:0] de,
    output logic        hold,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        err_valid,
    output logic [7:0]  err_code
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_CHECK = 2'd2,
        S_SEND  = 2'd3
    } state_t;

    localparam logic [15:0] LEN_LIMIT = 16'(MAX_LEN);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_ptr, w_ptr_nxt;
    logic [15:0] r_count, w_count_nxt;
    logic        r_fn9, w_fn9_nxt;
    logic        r_hold, w_hold_nxt;
    logic        r_mem_rd, w_mem_rd_nxt;
    logic [15:0] r_mem_addr, w_mem_addr_nxt;
    logic [7:0]  r_tx_data, w_tx_data_nxt;
    logic        r_tx_valid, w_tx_valid_nxt;
    logic        r_err_valid, w_err_valid_nxt;
    logic [7:0]  r_err_code, w_err_code_nxt;

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 16'h0000;
            r_count     <= 16'h0000;
            r_fn9       <= 1'b0;
            r_hold      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_code  <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_count     <= w_count_nxt;
            r_fn9       <= w_fn9_nxt;
            r_hold      <= w_hold_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_valid  <= w_tx_valid_nxt;
            r_err_valid <= w_err_valid_nxt;
            r_err_code  <= w_err_code_nxt;
        end
    end

    // Next-state and next-output logic; mem_rd/hold are precomputed so they are
    // registered in the same cycle the FSM enters FETCH / leaves IDLE.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_count_nxt     = r_count;
        w_fn9_nxt       = r_fn9;
        w_mem_rd_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_tx_data_nxt   = r_tx_data;
        w_tx_valid_nxt  = r_tx_valid;
        w_err_valid_nxt = 1'b0;
        w_err_code_nxt  = r_err_code;
        case (r_state)
            S_IDLE: begin
                if (m1 && (pc == BDOS_ADDR)) begin
                    if (c_reg == 8'd2) begin
                        w_tx_data_nxt  = de[7:0];
                        w_tx_valid_nxt = 1'b1;
                        w_fn9_nxt      = 1'b0;
                        w_state_nxt    = S_SEND;
                    end else if (c_reg == 8'd9) begin
                        w_ptr_nxt      = de;
                        w_count_nxt    = 16'h0000;
                        w_fn9_nxt      = 1'b1;
                        w_mem_rd_nxt   = 1'b1;
                        w_mem_addr_nxt = de;
                        w_state_nxt    = S_FETCH;
                    end else begin
                        w_err_valid_nxt = 1'b1;
                        w_err_code_nxt  = c_reg;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (mem_data == TERM) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count == LEN_LIMIT) begin
                    w_err_valid_nxt = 1'b1;
                    w_err_code_nxt  = 8'hFF;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_tx_data_nxt  = mem_data;
                    w_tx_valid_nxt = 1'b1;
                    w_state_nxt    = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    w_tx_valid_nxt = 1'b0;
                    if (r_fn9) begin
                        w_ptr_nxt      = r_ptr + 16'd1;
                        w_count_nxt    = r_count + 16'd1;
                        w_mem_rd_nxt   = 1'b1;
                        w_mem_addr_nxt = r_ptr + 16'd1;
                        w_state_nxt    = S_FETCH;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_SEND;
                end
            end
            default: begin
                w_tx_valid_nxt = 1'b0;
                w_state_nxt    = S_IDLE;
            end
        endcase
        w_hold_nxt = (w_state_nxt != S_IDLE);
    end

    assign hold      = r_hold;
    assign mem_rd    = r_mem_rd;
    assign mem_addr  = r_mem_addr;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign err_valid = r_err_valid;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_bdos_console.sv
// Scoreboard bench for bdos_console: expected console bytes, RAM read addresses and
// error codes are queued as calls are issued and popped by negedge monitors.
module tb_bdos_console;

    logic        clk = 1'b0;
    logic        rst;
    logic        m1, m1_b;
    logic [15:0] pc;
    logic [7:0]  c_reg;
    logic [15:0] de;
    logic        tx_ready;

    logic        hold, mem_rd, tx_valid, err_valid;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data, tx_data, err_code;

    logic        hold_b, mem_rd_b, tx_valid_b, err_valid_b;
    logic [15:0] mem_addr_b;
    logic [7:0]  mem_data_b, tx_data_b, err_code_b;

    logic [7:0]  ram [0:65535];

    logic [7:0]  exp_tx[$], exp_err[$], exp_tx_b[$], exp_err_b[$];
    logic [15:0] exp_addr[$];
    logic [7:0]  mon_e, mon_eb, mon_er, mon_erb;
    logic [15:0] mon_ea;

    int n_pass = 0;
    int n_total = 0;
    int n_rd = 0;
    int n_rd_b = 0;
    int hold_cnt;
    int rd_before;

    always #5 clk = ~clk;

    bdos_console dut (
        .clk(clk), .rst(rst), .m1(m1), .pc(pc), .c_reg(c_reg), .de(de),
        .hold(hold), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .err_valid(err_valid), .err_code(err_code)
    );

    bdos_console #(.MAX_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .m1(m1_b), .pc(pc), .c_reg(c_reg), .de(de),
        .hold(hold_b), .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
        .err_valid(err_valid_b), .err_code(err_code_b)
    );

    // Synchronous RAM: data for the address presented in one cycle appears in the next.
    always @(posedge clk) begin
        mem_data   <= ram[mem_addr];
        mem_data_b <= ram[mem_addr_b];
    end

    // Console byte monitor, main instance.
    always @(negedge clk) begin
        if (rst && tx_valid && tx_ready) begin
            n_total++;
            if (exp_tx.size() == 0) begin
                $display("FAIL tx_byte: got unexpected byte %h, required none", tx_data);
            end else begin
                mon_e = exp_tx.pop_front();
                if (tx_data !== mon_e) $display("FAIL tx_byte: got %h, required %h", tx_data, mon_e);
                else n_pass++;
            end
        end
    end

    // RAM read address monitor, main instance.
    always @(negedge clk) begin
        if (rst && mem_rd) begin
            n_rd++;
            n_total++;
            if (exp_addr.size() == 0) begin
                $display("FAIL mem_addr: got unexpected read %h, required none", mem_addr);
            end else begin
                mon_ea = exp_addr.pop_front();
                if (mem_addr !== mon_ea) $display("FAIL mem_addr: got %h, required %h", mem_addr, mon_ea);
                else n_pass++;
            end
        end
        if (rst && mem_rd_b) n_rd_b++;
    end

    // Error pulse monitor, main instance.
    always @(negedge clk) begin
        if (rst && err_valid) begin
            n_total++;
            if (exp_err.size() == 0) begin
                $display("FAIL err_code: got unexpected error %h, required none", err_code);
            end else begin
                mon_er = exp_err.pop_front();
                if (err_code !== mon_er) $display("FAIL err_code: got %h, required %h", err_code, mon_er);
                else n_pass++;
            end
        end
    end

    // Byte and error monitor for the MAX_LEN=4 instance.
    always @(negedge clk) begin
        if (rst && tx_valid_b && tx_ready) begin
            n_total++;
            if (exp_tx_b.size() == 0) begin
                $display("FAIL tx_byte_b: got unexpected byte %h, required none", tx_data_b);
            end else begin
                mon_eb = exp_tx_b.pop_front();
                if (tx_data_b !== mon_eb) $display("FAIL tx_byte_b: got %h, required %h", tx_data_b, mon_eb);
                else n_pass++;
            end
        end
        if (rst && err_valid_b) begin
            n_total++;
            if (exp_err_b.size() == 0) begin
                $display("FAIL err_code_b: got unexpected error %h, required none", err_code_b);
            end else begin
                mon_erb = exp_err_b.pop_front();
                if (err_code_b !== mon_erb) $display("FAIL err_code_b: got %h, required %h", err_code_b, mon_erb);
                else n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic trigger(input logic [7:0] c, input logic [15:0] d, input logic sel_b);
        pc = 16'h0005; c_reg = c; de = d;
        if (sel_b) m1_b = 1'b1;
        else       m1 = 1'b1;
        tick();
        m1 = 1'b0; m1_b = 1'b0; pc = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_total++;
        if ({hold, mem_rd, tx_valid, err_valid, tx_data, err_code, mem_addr} !== 36'h0)
            $display("FAIL reset_state: got %b%b%b%b %h %h %h, required all zero",
                     hold, mem_rd, tx_valid, err_valid, tx_data, err_code, mem_addr);
        else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fn2(input logic [7:0] ch);
        rd_before = n_rd;
        exp_tx.push_back(ch);
        trigger(8'd2, {8'h00, ch}, 1'b0);
        n_total++;
        if (hold !== 1'b1 || tx_valid !== 1'b1 || tx_data !== ch)
            $display("FAIL fn2_t1: got hold=%b valid=%b data=%h, required 1 1 %h", hold, tx_valid, tx_data, ch);
        else n_pass++;
        tick();
        n_total++;
        if (hold !== 1'b0 || tx_valid !== 1'b0)
            $display("FAIL fn2_t2: got hold=%b valid=%b, required 0 0", hold, tx_valid);
        else n_pass++;
        n_total++;
        if (exp_tx.size() != 0 || n_rd != rd_before)
            $display("FAIL fn2_done: got pending=%0d reads=%0d, required 0 0", exp_tx.size(), n_rd - rd_before);
        else n_pass++;
    endtask

    task automatic test_fn9_hi();
        ram[16'h0200] = 8'h48; ram[16'h0201] = 8'h49; ram[16'h0202] = 8'h24;
        exp_tx.push_back(8'h48); exp_tx.push_back(8'h49);
        exp_addr.push_back(16'h0200); exp_addr.push_back(16'h0201); exp_addr.push_back(16'h0202);
        trigger(8'd9, 16'h0200, 1'b0);
        hold_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            if (hold) hold_cnt++;
            if (k == 3 || k == 6) begin
                n_total++;
                if (tx_valid !== 1'b1 || tx_data !== ((k == 3) ? 8'h48 : 8'h49))
                    $display("FAIL fn9_send_k%0d: got valid=%b data=%h", k, tx_valid, tx_data);
                else n_pass++;
            end
            if (k == 10) begin
                n_total++;
                if (hold !== 1'b0) $display("FAIL fn9_hold_end: got %b, required 0", hold);
                else n_pass++;
            end
            tick();
        end
        n_total++;
        if (hold_cnt != 8 || exp_tx.size() != 0 || exp_addr.size() != 0)
            $display("FAIL fn9_hi: got hold_cycles=%0d pending=%0d/%0d, required 8 0/0",
                     hold_cnt, exp_tx.size(), exp_addr.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        exp_tx.push_back(8'h48); exp_tx.push_back(8'h49);
        exp_addr.push_back(16'h0200); exp_addr.push_back(16'h0201); exp_addr.push_back(16'h0202);
        trigger(8'd9, 16'h0200, 1'b0);
        hold_cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            tx_ready = (k >= 3 && k <= 6) ? 1'b0 : 1'b1;
            if (hold) hold_cnt++;
            if (k >= 3 && k <= 7) begin
                n_total++;
                if (tx_valid !== 1'b1 || tx_data !== 8'h48)
                    $display("FAIL bp_stable_k%0d: got valid=%b data=%h, required 1 48", k, tx_valid, tx_data);
                else n_pass++;
            end
            tick();
        end
        tx_ready = 1'b1;
        n_total++;
        if (hold_cnt != 12 || exp_tx.size() != 0)
            $display("FAIL bp_hold: got hold_cycles=%0d pending=%0d, required 12 0", hold_cnt, exp_tx.size());
        else n_pass++;
    endtask

    task automatic test_wrap();
        ram[16'hFFFF] = 8'h41; ram[16'h0000] = 8'h24;
        exp_tx.push_back(8'h41);
        exp_addr.push_back(16'hFFFF); exp_addr.push_back(16'h0000);
        trigger(8'd9, 16'hFFFF, 1'b0);
        for (int k = 0; k < 20 && hold; k++) tick();
        tick();
        n_total++;
        if (hold !== 1'b0 || exp_tx.size() != 0 || exp_addr.size() != 0)
            $display("FAIL wrap: got hold=%b pending=%0d/%0d, required 0 0/0", hold, exp_tx.size(), exp_addr.size());
        else n_pass++;
    endtask

    task automatic test_unsupported();
        exp_err.push_back(8'h0B);
        trigger(8'h0B, 16'h1234, 1'b0);
        n_total++;
        if (err_valid !== 1'b1 || err_code !== 8'h0B || hold !== 1'b0)
            $display("FAIL unsup_t1: got err=%b code=%h hold=%b, required 1 0b 0", err_valid, err_code, hold);
        else n_pass++;
        tick();
        n_total++;
        if (err_valid !== 1'b0 || hold !== 1'b0 || exp_err.size() != 0)
            $display("FAIL unsup_t2: got err=%b hold=%b pending=%0d, required 0 0 0", err_valid, hold, exp_err.size());
        else n_pass++;
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 8; i++) ram[16'h0300 + 16'(i)] = 8'h41 + 8'(i);
        for (int i = 0; i < 4; i++) exp_tx_b.push_back(8'h41 + 8'(i));
        exp_err_b.push_back(8'hFF);
        rd_before = n_rd_b;
        trigger(8'd9, 16'h0300, 1'b1);
        for (int k = 0; k < 40 && hold_b; k++) tick();
        tick();
        tick();
        n_total++;
        if (hold_b !== 1'b0 || exp_tx_b.size() != 0 || exp_err_b.size() != 0 || n_rd_b - rd_before != 5)
            $display("FAIL overrun: got hold=%b pending=%0d/%0d reads=%0d, required 0 0/0 5",
                     hold_b, exp_tx_b.size(), exp_err_b.size(), n_rd_b - rd_before);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        ram[16'h0400] = 8'h58; ram[16'h0401] = 8'h59; ram[16'h0402] = 8'h5A; ram[16'h0403] = 8'h24;
        exp_tx.push_back(8'h58);
        exp_addr.push_back(16'h0400); exp_addr.push_back(16'h0401);
        trigger(8'd9, 16'h0400, 1'b0);
        for (int k = 1; k < 6; k++) tick();
        tx_ready = 1'b0;
        n_total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h59 || hold !== 1'b1)
            $display("FAIL rstmid_pre: got valid=%b data=%h hold=%b, required 1 59 1", tx_valid, tx_data, hold);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++;
        if (hold !== 1'b0 || tx_valid !== 1'b0 || mem_rd !== 1'b0)
            $display("FAIL rstmid_async: got hold=%b valid=%b rd=%b, required 0 0 0", hold, tx_valid, mem_rd);
        else n_pass++;
        tick();
        rst = 1'b1;
        tx_ready = 1'b1;
        tick();
        n_total++;
        if (exp_tx.size() != 0 || exp_addr.size() != 0)
            $display("FAIL rstmid_queue: got pending=%0d/%0d, required 0/0", exp_tx.size(), exp_addr.size());
        else n_pass++;
        test_fn2(8'h5A);
    endtask

    initial begin
        m1 = 1'b0; m1_b = 1'b0; pc = 16'h0000; c_reg = 8'h00; de = 16'h0000;
        tx_ready = 1'b1;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        test_reset();
        test_fn2(8'h41);
        test_fn9_hi();
        test_backpressure();
        test_wrap();
        test_unsupported();
        test_overrun();
        test_reset_mid();
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
